bit_instr_seq: RTL and testbench

- Instruction sequencer directly upstream of the bit unit in each PLC core.
- Fetches bit-logic instruction words from program memory over a req/ack handshake and decodes them.
- Drives the bit unit's write enable and its A/B/LU opcodes plus the immediate argument.
- Stalls on RAM reads and uses the returned accumulator bit (A) for conditional jumps, which closes the scan loop.

---
 rtl/bit_instr_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_bit_instr_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_instr_seq.sv
// bit_instr_seq: bit-logic instruction sequencer that feeds the PLC bit unit.
// Fetches 16-bit words ([15:11] op, [10] imm, [9:0] addr/target) over a
// req/ack handshake, decodes them and drives the bit unit's write enable and
// operand selects. RAM-sourced ops stall until the bit read returns.
// Optional build macro: BITSEQ_WATCHDOG_EN enables a scan-cycle watchdog
// that aborts a scan after WDT_LIMIT busy cycles and raises SEQ_Fault.
module bit_instr_seq #(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 16,
  parameter int WDT_LIMIT = 4095
) (
  input  logic               CLK,
  input  logic               CPU_Reset,
  input  logic               SEQ_Start,
  output logic               SEQ_Busy,
  output logic               SEQ_Done,
  output logic               SEQ_Fault,
  output logic               PM_Req,
  output logic [PC_W-1:0]    PM_Addr,
  input  logic               PM_Ack,
  input  logic [INSTR_W-1:0] PM_Data,
  output logic               RAM_Req,
  output logic [PC_W-1:0]    RAM_Addr,
  input  logic               RAM_Valid,
  input  logic               BITUNIT_A,
  output logic               BITUNIT_A_WE,
  output logic [2:0]         BITUNIT_A_OPCode,
  output logic [1:0]         BITUNIT_B_OPCode,
  output logic [1:0]         BITUNIT_LU_OPCode,
  output logic               BITUNIT_ArgToSet
);

  // state     | meaning
  // ----------+------------------------------------------------------------
  // ST_IDLE   | waiting for SEQ_Start; all bit-unit outputs quiet
  // ST_FETCH  | PM_Req held with PM_Addr=PC until PM_Ack loads IR
  // ST_EXEC   | one-cycle decode/execute of IR; RAM ops issue RAM_Req here
  // ST_WAIT_RAM | stalled on RAM bit read; writes A on RAM_Valid
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_EXEC     = 2'd2,
    ST_WAIT_RAM = 2'd3
  } state_t;

  localparam logic [4:0] OP_LDI   = 5'h01;
  localparam logic [4:0] OP_LDM   = 5'h02;
  localparam logic [4:0] OP_LDOV  = 5'h04;
  localparam logic [4:0] OP_LDCMP = 5'h05;
  localparam logic [4:0] OP_LDSEM = 5'h06;
  localparam logic [4:0] OP_JMP   = 5'h10;
  localparam logic [4:0] OP_JMPC  = 5'h11;
  localparam logic [4:0] OP_JMPCN = 5'h12;
  localparam logic [4:0] OP_END   = 5'h1F;

  localparam logic [2:0] A_IMM = 3'd0;
  localparam logic [2:0] A_RAM = 3'd1;
  localparam logic [2:0] A_LU  = 3'd3;
  localparam logic [2:0] A_OV  = 3'd4;
  localparam logic [2:0] A_CMP = 3'd5;
  localparam logic [2:0] A_SEM = 3'd6;

  localparam logic [1:0] B_IMM = 2'd0;
  localparam logic [1:0] B_RAM = 2'd1;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  logic [4:0]           op;
  logic                 imm;
  logic [PC_W-1:0]      target;
  logic [PC_W-1:0]      pc_inc;
  logic                 is_ram_op;
  logic                 is_lu_imm;

  logic                 a_we;
  logic [2:0]           a_op;
  logic [1:0]           b_op;
  logic [1:0]           lu_op;
  logic                 ram_req;
  logic                 done;

`ifdef BITSEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);
  // Down-counter of remaining busy cycles; terminal count at zero aborts.
  logic [WDT_W-1:0]     wdt_q, wdt_d;
  logic                 fault_q, fault_d;
`else
  logic                 unused_wdt_limit;
  assign unused_wdt_limit = ^WDT_LIMIT;
`endif

  assign op        = ir_q[INSTR_W-1 -: 5];
  assign imm       = ir_q[INSTR_W-6];
  assign target    = ir_q[PC_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  // LDM and the four LU-RAM ops (0x0C-0x0F) need a RAM bit before A can be written.
  assign is_ram_op = (op == OP_LDM) || (op[4:2] == 3'b011);
  assign is_lu_imm = (op[4:2] == 3'b010);

  // Next-state, PC/IR update and bit-unit control decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_we    = 1'b0;
    a_op    = A_IMM;
    b_op    = B_IMM;
    lu_op   = 2'd0;
    ram_req = 1'b0;
    done    = 1'b0;
`ifdef BITSEQ_WATCHDOG_EN
    wdt_d   = wdt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (SEQ_Start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
`ifdef BITSEQ_WATCHDOG_EN
          fault_d = 1'b0;
          wdt_d   = WDT_W'(WDT_LIMIT - 1);
`endif
        end
      end
      ST_FETCH: begin
        if (PM_Ack) begin
          ir_d    = PM_Data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_ram_op) begin
          // PC stays put; it advances once the RAM operand has been consumed.
          ram_req = 1'b1;
          state_d = ST_WAIT_RAM;
        end else begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
          case (op)
            OP_LDI:   a_we = 1'b1;
            OP_LDOV:  begin a_we = 1'b1; a_op = A_OV;  end
            OP_LDCMP: begin a_we = 1'b1; a_op = A_CMP; end
            OP_LDSEM: begin a_we = 1'b1; a_op = A_SEM; end
            OP_JMP:   pc_d = target;
            OP_JMPC:  if (BITUNIT_A)  pc_d = target;
            OP_JMPCN: if (!BITUNIT_A) pc_d = target;
            OP_END: begin
              done    = 1'b1;
              pc_d    = '0;
              state_d = ST_IDLE;
            end
            default: begin
              // Unlisted opcodes fall through as NOP.
              if (is_lu_imm) begin
                a_we  = 1'b1;
                a_op  = A_LU;
                lu_op = op[1:0];
              end
            end
          endcase
        end
      end
      ST_WAIT_RAM: begin
        if (RAM_Valid) begin
          a_we = 1'b1;
          if (op == OP_LDM) begin
            a_op = A_RAM;
          end else begin
            a_op  = A_LU;
            b_op  = B_RAM;
            lu_op = op[1:0];
          end
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef BITSEQ_WATCHDOG_EN
    // Abort wins over anything the current state wanted, including END.
    if (state_q != ST_IDLE) begin
      if (wdt_q == '0) begin
        state_d = ST_IDLE;
        pc_d    = '0;
        fault_d = 1'b1;
        done    = 1'b0;
        a_we    = 1'b0;
        a_op    = A_IMM;
        b_op    = B_IMM;
        lu_op   = 2'd0;
        ram_req = 1'b0;
      end else begin
        wdt_d = wdt_q - WDT_W'(1);
      end
    end
`endif
  end

  // All sequencer state; async active-low reset returns to IDLE with PC=IR=0.
  always_ff @(posedge CLK or negedge CPU_Reset) begin
    if (!CPU_Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
`ifdef BITSEQ_WATCHDOG_EN
      wdt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef BITSEQ_WATCHDOG_EN
      wdt_q   <= wdt_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign SEQ_Busy          = (state_q != ST_IDLE);
  assign SEQ_Done          = done;
`ifdef BITSEQ_WATCHDOG_EN
  assign SEQ_Fault         = fault_q;
`else
  assign SEQ_Fault         = 1'b0;
`endif
  assign PM_Req            = (state_q == ST_FETCH);
  assign PM_Addr           = pc_q;
  assign RAM_Req           = ram_req;
  assign RAM_Addr          = target;
  assign BITUNIT_A_WE      = a_we;
  assign BITUNIT_A_OPCode  = a_op;
  assign BITUNIT_B_OPCode  = b_op;
  assign BITUNIT_LU_OPCode = lu_op;
  assign BITUNIT_ArgToSet  = a_we & imm;

endmodule

// File: tb/tb_bit_instr_seq.sv
// Testbench for bit_instr_seq: bench plays program memory, bit RAM and bit
// unit, and checks the sequencer against an instruction-level interpreter.
module tb_bit_instr_seq;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;

  logic               CLK = 1'b0;
  logic               CPU_Reset = 1'b0;
  logic               SEQ_Start = 1'b0;
  logic               SEQ_Busy, SEQ_Done, SEQ_Fault;
  logic               PM_Req;
  logic [PC_W-1:0]    PM_Addr;
  logic               PM_Ack = 1'b0;
  logic [INSTR_W-1:0] PM_Data = '0;
  logic               RAM_Req;
  logic [PC_W-1:0]    RAM_Addr;
  logic               RAM_Valid = 1'b0;
  logic               BITUNIT_A = 1'b0;
  logic               BITUNIT_A_WE;
  logic [2:0]         BITUNIT_A_OPCode;
  logic [1:0]         BITUNIT_B_OPCode;
  logic [1:0]         BITUNIT_LU_OPCode;
  logic               BITUNIT_ArgToSet;

  bit_instr_seq dut (
    .CLK               (CLK),
    .CPU_Reset         (CPU_Reset),
    .SEQ_Start         (SEQ_Start),
    .SEQ_Busy          (SEQ_Busy),
    .SEQ_Done          (SEQ_Done),
    .SEQ_Fault         (SEQ_Fault),
    .PM_Req            (PM_Req),
    .PM_Addr           (PM_Addr),
    .PM_Ack            (PM_Ack),
    .PM_Data           (PM_Data),
    .RAM_Req           (RAM_Req),
    .RAM_Addr          (RAM_Addr),
    .RAM_Valid         (RAM_Valid),
    .BITUNIT_A         (BITUNIT_A),
    .BITUNIT_A_WE      (BITUNIT_A_WE),
    .BITUNIT_A_OPCode  (BITUNIT_A_OPCode),
    .BITUNIT_B_OPCode  (BITUNIT_B_OPCode),
    .BITUNIT_LU_OPCode (BITUNIT_LU_OPCode),
    .BITUNIT_ArgToSet  (BITUNIT_ArgToSet)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [1024];
  logic        ram_bits [1024];
  logic        model_a = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic lu_fn(input logic a, input logic b, input logic [1:0] f);
    case (f)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return !(a & b);
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      prog[i]     = 16'hF800;
      ram_bits[i] = rbit();
    end
  endtask

  // Random program: every opcode except END in the body, forward-only jumps, END last.
  task automatic gen_prog(input int len);
    clear_mem();
    for (int i = 0; i < len - 1; i++) begin
      logic [4:0] rop;
      logic [9:0] t;
      rop = 5'($urandom_range(31, 0));
      if (rop == 5'h1F) rop = 5'h00;
      t = 10'($urandom_range(1023, 0));
      if (rop == 5'h10 || rop == 5'h11 || rop == 5'h12)
        t = 10'($urandom_range(len - 1, i + 1));
      prog[i] = {rop, rbit(), t};
    end
  endtask

  // Runs one scan in lockstep with an instruction-level interpreter of prog[].
  task automatic run_scan(input int ack_lo, input int ack_hi, input int ram_lo, input int ram_hi,
                          input bit noise, output int done_cyc);
    logic [9:0]  pc;
    logic [15:0] w;
    logic [4:0]  op;
    logic        imm;
    logic [9:0]  tgt;
    logic [9:0]  nxt;
    logic        new_a;
    logic        e_we;
    logic [2:0]  e_aop;
    logic [1:0]  e_bop, e_lu;
    int          cyc, steps, d;
    bit          fin;
    pc = '0; cyc = 0; steps = 0; fin = 0; done_cyc = -1;
    BITUNIT_A = model_a;
    SEQ_Start = 1'b1;
    #1;
    tick(); cyc = 1;
    SEQ_Start = 1'b0;
    while (!fin && steps < 400) begin
      steps++;
      d = int'($urandom_range(ack_hi, ack_lo));
      for (int i = 0; i < d; i++) begin
        PM_Ack    = 1'b0;
        RAM_Valid = noise ? rbit() : 1'b0;
        SEQ_Start = noise ? rbit() : 1'b0;
        #1;
        check_val("wait_pm_req", 32'(PM_Req), 32'd1);
        check_val("wait_pm_addr", 32'(PM_Addr), 32'(pc));
        check_val("wait_no_we", 32'(BITUNIT_A_WE), 32'd0);
        tick(); cyc++;
      end
      PM_Ack    = 1'b1;
      PM_Data   = prog[pc];
      RAM_Valid = noise ? rbit() : 1'b0;
      #1;
      check_val("ack_pm_req", 32'(PM_Req), 32'd1);
      check_val("ack_pm_addr", 32'(PM_Addr), 32'(pc));
      check_val("ack_no_we", 32'(BITUNIT_A_WE), 32'd0);
      tick(); cyc++;
      w   = prog[pc];
      op  = w[15:11];
      imm = w[10];
      tgt = w[9:0];
      PM_Ack  = noise ? rbit() : 1'b0;
      PM_Data = 16'($urandom);
      RAM_Valid = noise ? rbit() : 1'b0;
      #1;
      if (op == 5'h02 || (op >= 5'h0C && op <= 5'h0F)) begin
        check_val("exec_ram_req", 32'(RAM_Req), 32'd1);
        check_val("exec_ram_addr", 32'(RAM_Addr), 32'(tgt));
        check_val("exec_ram_no_we", 32'(BITUNIT_A_WE), 32'd0);
        tick(); cyc++;
        d = int'($urandom_range(ram_hi, ram_lo));
        for (int i = 0; i < d; i++) begin
          RAM_Valid = 1'b0;
          PM_Ack    = noise ? rbit() : 1'b0;
          #1;
          check_val("stall_no_we", 32'(BITUNIT_A_WE), 32'd0);
          check_val("stall_ram_req", 32'(RAM_Req), 32'd0);
          check_val("stall_pm_req", 32'(PM_Req), 32'd0);
          tick(); cyc++;
        end
        RAM_Valid = 1'b1;
        PM_Ack    = noise ? rbit() : 1'b0;
        #1;
        e_aop = (op == 5'h02) ? 3'd1 : 3'd3;
        e_bop = (op == 5'h02) ? 2'd0 : 2'd1;
        e_lu  = (op == 5'h02) ? 2'd0 : op[1:0];
        check_val("ram_we", 32'(BITUNIT_A_WE), 32'd1);
        check_val("ram_a_op", 32'(BITUNIT_A_OPCode), 32'(e_aop));
        check_val("ram_b_op", 32'(BITUNIT_B_OPCode), 32'(e_bop));
        check_val("ram_lu_op", 32'(BITUNIT_LU_OPCode), 32'(e_lu));
        check_val("ram_arg", 32'(BITUNIT_ArgToSet), 32'(imm));
        model_a = (op == 5'h02) ? ram_bits[tgt] : lu_fn(model_a, ram_bits[tgt], op[1:0]);
        tick(); cyc++;
        RAM_Valid = 1'b0;
        BITUNIT_A = model_a;
        pc = pc + 10'd1;
      end else begin
        e_we = 1'b0; e_aop = 3'd0; e_bop = 2'd0; e_lu = 2'd0;
        nxt = pc + 10'd1;
        new_a = model_a;
        case (op)
          5'h01: begin e_we = 1'b1; new_a = imm; end
          5'h04: begin e_we = 1'b1; e_aop = 3'd4; new_a = rbit(); end
          5'h05: begin e_we = 1'b1; e_aop = 3'd5; new_a = rbit(); end
          5'h06: begin e_we = 1'b1; e_aop = 3'd6; new_a = rbit(); end
          5'h08, 5'h09, 5'h0A, 5'h0B: begin
            e_we = 1'b1; e_aop = 3'd3; e_lu = op[1:0];
            new_a = lu_fn(model_a, imm, op[1:0]);
          end
          5'h10: nxt = tgt;
          5'h11: if (model_a)  nxt = tgt;
          5'h12: if (!model_a) nxt = tgt;
          5'h1F: fin = 1;
          default: ;
        endcase
        check_val("exec_we", 32'(BITUNIT_A_WE), 32'(e_we));
        check_val("exec_a_op", 32'(BITUNIT_A_OPCode), 32'(e_aop));
        check_val("exec_b_op", 32'(BITUNIT_B_OPCode), 32'(e_bop));
        check_val("exec_lu_op", 32'(BITUNIT_LU_OPCode), 32'(e_lu));
        check_val("exec_arg", 32'(BITUNIT_ArgToSet), 32'(e_we & imm));
        check_val("exec_done", 32'(SEQ_Done), 32'(fin));
        check_val("exec_no_ram_req", 32'(RAM_Req), 32'd0);
        if (fin) done_cyc = cyc;
        tick(); cyc++;
        model_a   = new_a;
        BITUNIT_A = model_a;
        pc = fin ? 10'd0 : nxt;
      end
    end
    SEQ_Start = 1'b0;
    PM_Ack    = 1'b0;
    RAM_Valid = 1'b0;
    #1;
    check_val("scan_finished", 32'(fin), 32'd1);
    check_val("idle_busy", 32'(SEQ_Busy), 32'd0);
    check_val("idle_done_low", 32'(SEQ_Done), 32'd0);
    check_val("idle_fault", 32'(SEQ_Fault), 32'd0);
    check_val("idle_pm_req", 32'(PM_Req), 32'd0);
    check_val("idle_pm_addr", 32'(PM_Addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    clear_mem();

    // Reset with noisy inputs: everything must stay at zero.
    SEQ_Start = 1'b1; PM_Ack = 1'b1; RAM_Valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_busy", 32'(SEQ_Busy), 32'd0);
    check_val("rst_done", 32'(SEQ_Done), 32'd0);
    check_val("rst_fault", 32'(SEQ_Fault), 32'd0);
    check_val("rst_pm_req", 32'(PM_Req), 32'd0);
    check_val("rst_pm_addr", 32'(PM_Addr), 32'd0);
    check_val("rst_ram_req", 32'(RAM_Req), 32'd0);
    check_val("rst_ram_addr", 32'(RAM_Addr), 32'd0);
    check_val("rst_we", 32'(BITUNIT_A_WE), 32'd0);
    check_val("rst_ops", 32'({BITUNIT_A_OPCode, BITUNIT_B_OPCode, BITUNIT_LU_OPCode, BITUNIT_ArgToSet}), 32'd0);
    SEQ_Start = 1'b0; RAM_Valid = 1'b0;
    CPU_Reset = 1'b1;
    // Stray ack while idle is ignored.
    tick();
    PM_Ack = 1'b0;
    #1;
    check_val("stray_ack_idle", 32'(SEQ_Busy), 32'd0);

    // LDI 1; AND-imm 0; END with zero-wait ack: Done in cycle 6.
    clear_mem();
    prog[0] = {5'h01, 1'b1, 10'h000};
    prog[1] = {5'h08, 1'b0, 10'h000};
    prog[2] = {5'h1F, 1'b0, 10'h000};
    run_scan(0, 0, 0, 0, 1'b0, dc);
    check_val("done_cycle_zero_wait", 32'(dc), 32'd6);

    // Same program with a 5-cycle ack latency: 3 x (6 fetch + 1 exec).
    run_scan(5, 5, 0, 0, 1'b0, dc);
    check_val("done_cycle_ack5", 32'(dc), 32'd21);

    // LDM 0x155, RAM_Valid three cycles after RAM_Req.
    clear_mem();
    prog[0] = {5'h02, 1'b0, 10'h155};
    prog[1] = {5'h1F, 1'b0, 10'h000};
    ram_bits[10'h155] = 1'b1;
    run_scan(0, 0, 2, 2, 1'b0, dc);
    check_val("ldm_loaded_a", 32'(model_a), 32'd1);

    // JMPC taken with A=1, then falls through with A=0.
    clear_mem();
    prog[0]     = {5'h01, 1'b1, 10'h000};
    prog[1]     = {5'h11, 1'b0, 10'h040};
    prog[10'h40] = {5'h01, 1'b0, 10'h000};
    prog[10'h41] = {5'h11, 1'b0, 10'h080};
    prog[10'h42] = {5'h12, 1'b0, 10'h050};
    prog[10'h50] = {5'h1F, 1'b0, 10'h000};
    run_scan(0, 1, 0, 0, 1'b0, dc);

    // PC wrap from 0x3FF to 0.
    clear_mem();
    model_a = 1'b1;
    prog[0]      = {5'h11, 1'b0, 10'h3FF};
    prog[10'h3FF] = {5'h01, 1'b0, 10'h000};
    prog[1]      = {5'h1F, 1'b0, 10'h000};
    run_scan(0, 0, 0, 0, 1'b0, dc);

    // Reset while stalled in WAIT_RAM.
    clear_mem();
    prog[0] = {5'h02, 1'b0, 10'h0AA};
    SEQ_Start = 1'b1;
    #1;
    tick();
    SEQ_Start = 1'b0;
    PM_Ack = 1'b1; PM_Data = prog[0];
    #1;
    tick();
    PM_Ack = 1'b0;
    #1;
    check_val("wr_exec_ram_req", 32'(RAM_Req), 32'd1);
    tick();
    #1;
    check_val("wr_busy_before", 32'(SEQ_Busy), 32'd1);
    check_val("wr_ram_addr_before", 32'(RAM_Addr), 32'h0AA);
    CPU_Reset = 1'b0;
    #1;
    check_val("wr_busy_async", 32'(SEQ_Busy), 32'd0);
    check_val("wr_ram_addr_async", 32'(RAM_Addr), 32'd0);
    check_val("wr_pm_req_async", 32'(PM_Req), 32'd0);
    RAM_Valid = 1'b1;
    #1;
    check_val("wr_we_in_reset", 32'(BITUNIT_A_WE), 32'd0);
    tick();
    RAM_Valid = 1'b0;
    CPU_Reset = 1'b1;
    tick();
    RAM_Valid = 1'b1;
    #1;
    check_val("wr_late_valid_we", 32'(BITUNIT_A_WE), 32'd0);
    check_val("wr_late_valid_busy", 32'(SEQ_Busy), 32'd0);
    tick();
    RAM_Valid = 1'b0;
    #1;
    check_val("wr_still_idle", 32'(SEQ_Busy), 32'd0);

    // Random programs with random latencies and stray handshake/start noise.
    for (int s = 0; s < 10; s++) begin
      gen_prog(int'($urandom_range(30, 8)));
      run_scan(0, 3, 0, 4, 1'b1, dc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
